// File: rtl/axis_pixel_fifo_pkg.sv
// starsoc_params: shared AXI-Stream pixel constants, beat layout and resync state encoding
package starsoc_params;
    localparam int AXIS_PIXEL_W = 24;
    typedef struct packed {
        logic                    tuser;
        logic                    tlast;
        logic [AXIS_PIXEL_W-1:0] tdata;
    } axis_pixel_t;
    typedef enum logic [1:0] {SYNC_WAIT, PASS, DROP} axis_sync_state_t;
endpackage

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem: DEPTH x W dual-port RAM with synchronous write and asynchronous read
module axis_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 26
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);
    logic [W-1:0] r_mem [DEPTH];
    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axis_pixel_fifo.sv
// axis_pixel_fifo: FWFT AXI-Stream pixel FIFO with loss accounting; define AXIS_FIFO_FRAME_RESYNC_EN
// to drop input after a loss until the next start-of-frame beat.
module axis_pixel_fifo
    import starsoc_params::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = AXIS_PIXEL_W
) (
    input  logic                       pixel_clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tuser,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tuser,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    input  logic                       clr_err
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]       r_wptr, r_rptr, r_level, w_wptr_nxt, w_rptr_nxt;
    logic              r_full, r_overflow, w_empty, w_wr, w_rd, w_lost, w_accept;
    logic [15:0]       r_drop_count;
    logic [DATA_W+1:0] w_rdata;
    assign w_empty    = r_wptr == r_rptr;
    assign s_tready   = !r_full;
    assign m_tvalid   = !w_empty;
    assign w_wr       = s_tvalid && !r_full && w_accept;
    assign w_rd       = m_tvalid && m_tready;
    assign w_lost     = s_tvalid && r_full;
    assign w_wptr_nxt = r_wptr + (AW+1)'(w_wr);
    assign w_rptr_nxt = r_rptr + (AW+1)'(w_rd);
    assign {m_tuser, m_tlast, m_tdata} = w_empty ? '0 : w_rdata;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
`ifdef AXIS_FIFO_FRAME_RESYNC_EN
    axis_sync_state_t r_state;
    // Only a start-of-frame beat may leave SYNC_WAIT/DROP; a loss in PASS forces DROP.
    assign w_accept = r_state == PASS || s_tuser;
    always_ff @(posedge pixel_clk)
        if (reset) r_state <= SYNC_WAIT;
        else if (s_tvalid) r_state <= r_full ? (r_state == SYNC_WAIT ? SYNC_WAIT : DROP) : (w_accept ? PASS : r_state);
`else
    assign w_accept = 1'b1;
`endif
    axis_fifo_mem #(.DEPTH(DEPTH), .W(DATA_W + 2)) u_mem (
        .i_clk   (pixel_clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata ({s_tuser, s_tlast, s_tdata}),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rdata)
    );
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            r_full  <= (w_wptr_nxt ^ w_rptr_nxt) == {1'b1, {AW{1'b0}}};
            if (clr_err) begin
                r_overflow   <= 1'b0;
                r_drop_count <= '0;
            end else if (w_lost) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_pixel_fifo.sv
// tb_axis_pixel_fifo: table, directed and random checks of axis_pixel_fifo against a queue model
module tb_axis_pixel_fifo;
    localparam int DEPTH = 16;
    logic        pixel_clk = 0, reset = 1, s_tvalid = 0, s_tuser = 0, s_tlast = 0, m_tready = 0, clr_err = 0;
    logic [23:0] s_tdata = 0, m_tdata;
    logic        s_tready, m_tvalid, m_tuser, m_tlast, overflow;
    logic [4:0]  level;
    logic [15:0] drop_count;
    int          n_pass = 0, n_total = 0;
    logic [25:0] mq[$];
    bit          m_ovf;
    int          m_cnt, m_mode;
    logic [23:0] gen = 24'h100;

    axis_pixel_fifo #(.DEPTH(DEPTH), .DATA_W(24)) dut (
        .pixel_clk(pixel_clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser),
        .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tready(m_tready), .level(level), .overflow(overflow), .drop_count(drop_count),
        .clr_err(clr_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic drive(input bit v, input bit u, input bit l, input logic [23:0] d, input bit mr, input bit clr);
        s_tvalid = v; s_tuser = u; s_tlast = l; s_tdata = d; m_tready = mr; clr_err = clr;
    endtask

    // One clock: the model decides from pre-edge state and inputs, then DUT and model are compared.
    task automatic cycle(input bit do_chk);
        bit rdy, vld, acc, wr, rd, lost;
        rdy = mq.size() < DEPTH;
        vld = mq.size() > 0;
`ifdef AXIS_FIFO_FRAME_RESYNC_EN
        acc = m_mode == 1 || s_tuser;
`else
        acc = 1;
`endif
        wr = s_tvalid && rdy && acc;
        rd = vld && m_tready;
        lost = s_tvalid && !rdy;
        @(posedge pixel_clk);
        #1;
        if (reset) begin
            mq.delete(); m_ovf = 0; m_cnt = 0; m_mode = 0;
        end else begin
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back({s_tuser, s_tlast, s_tdata});
            if (clr_err) begin m_ovf = 0; m_cnt = 0; end
            else if (lost) begin m_ovf = 1; m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535; end
            if (s_tvalid) m_mode = lost ? (m_mode == 0 ? 0 : 2) : (wr ? 1 : m_mode);
        end
        if (do_chk) begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("m_tvalid", 32'(m_tvalid), 32'(mq.size() > 0));
            chk("s_tready", 32'(s_tready), 32'(mq.size() < DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_count", 32'(drop_count), 32'(m_cnt));
            if (mq.size() > 0) chk("m_beat", 32'({m_tuser, m_tlast, m_tdata}), 32'(mq[0]));
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1;
        cycle(1);
        reset = 0;
    endtask

    task automatic push(input bit sof, input bit mr);
        gen++;
        drive(1, sof, gen[2:0] == 3'd7, gen, mr, 0);
        cycle(1);
    endtask

    typedef struct {
        bit          v, u, mr;
        logic [23:0] d;
        int          lvl;
        bit          vld;
        logic [23:0] ed;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{1, 1, 0, 24'hA0A0A0, 1, 1, 24'hA0A0A0};
        tbl[1] = '{1, 0, 0, 24'hB1B1B1, 2, 1, 24'hA0A0A0};
        tbl[2] = '{0, 0, 1, 24'h000000, 1, 1, 24'hB1B1B1};
        tbl[3] = '{1, 0, 1, 24'hC2C2C2, 1, 1, 24'hC2C2C2};
        tbl[4] = '{0, 0, 1, 24'h000000, 0, 0, 24'h000000};
        tbl[5] = '{1, 1, 1, 24'hD3D3D3, 1, 1, 24'hD3D3D3};
        tbl[6] = '{0, 0, 1, 24'h000000, 0, 0, 24'h000000};

        do_reset();
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_tuser_tlast", 32'({m_tuser, m_tlast}), 0);
        chk("rst_ready", 32'(s_tready), 1);

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].u, 0, tbl[i].d, tbl[i].mr, 0);
            cycle(1);
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_valid", i), 32'(m_tvalid), 32'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), 32'(m_tdata), 32'(tbl[i].ed));
        end

        // fill, overflow, clear, drain
        do_reset();
        for (int i = 0; i < 16; i++) push(i == 0, 0);
        chk("fill_level", 32'(level), 16);
        chk("fill_ready", 32'(s_tready), 0);
        for (int i = 0; i < 3; i++) push(0, 0);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(drop_count), 3);
        drive(0, 0, 0, 0, 0, 1);
        cycle(1);
        chk("clr_flag", 32'(overflow), 0);
        chk("clr_count", 32'(drop_count), 0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(m_tdata), 32'(24'h101 + 24'(i)));
            drive(0, 0, 0, 0, 1, 0);
            cycle(1);
        end
        chk("drain_level", 32'(level), 0);
        chk("drain_valid", 32'(m_tvalid), 0);

        // simultaneous write and read at level 8
        do_reset();
        for (int i = 0; i < 8; i++) push(i == 0, 0);
        for (int i = 0; i < 100; i++) push(0, 1);
        chk("simul_level", 32'(level), 8);

`ifdef AXIS_FIFO_FRAME_RESYNC_EN
        do_reset();
        drive(1, 0, 0, 24'h111111, 0, 0);
        cycle(1);
        chk("syncwait_discard", 32'(level), 0);
        chk("syncwait_ready", 32'(s_tready), 1);
        for (int i = 0; i < 16; i++) push(i == 0, 0);
        push(0, 0);
        for (int i = 0; i < 4; i++) push(0, 1);
        chk("resync_discard", 32'(level), 12);
        drive(1, 1, 0, 24'hABCDEF, 1, 0);
        cycle(1);
        drive(0, 0, 0, 0, 0, 0);
        begin
            int k = 0;
            while (!(m_tvalid && m_tuser) && k < 40) begin
                m_tready = 1;
                cycle(1);
                k++;
            end
            chk("resync_found", 32'(k < 40), 1);
        end
        chk("resync_tuser", 32'(m_tuser), 1);
        chk("resync_data", 32'(m_tdata), 32'h00ABCDEF);
`endif

        // reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) push(i == 0, 0);
        chk("pre_rst_level", 32'(level), 5);
        do_reset();
        chk("midrst_valid", 32'(m_tvalid), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_ready", 32'(s_tready), 1);
        drive(1, 1, 0, 24'h5A5A5A, 0, 0);
        cycle(1);
        chk("midrst_first", 32'(m_tdata), 32'h005A5A5A);

        // saturation, then clr_err against a lost beat in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) push(i == 0, 0);
        drive(1, 0, 0, 24'h777777, 0, 0);
        for (int i = 0; i < 70000; i++) cycle(0);
        cycle(1);
        chk("sat_count", 32'(drop_count), 32'hFFFF);
        drive(1, 0, 0, 24'h777777, 0, 1);
        cycle(1);
        chk("clr_prio_count", 32'(drop_count), 0);
        chk("clr_prio_flag", 32'(overflow), 0);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 299) == 0;
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 7) == 0, $urandom_range(0, 1), 24'($urandom),
                  (i / 200) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
            cycle(1);
        end
        reset = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
